// File: rtl/tune_seq_pkg.sv
// Shared types and song-entry field layout for the tune sequencer.
// An entry is packed as {end, octave, note, dur} with dur in the LSBs.
package tune_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  localparam int NOTE_REST = 0;

  function automatic int entry_w(input int oct_w, input int note_w, input int dur_w);
    return 1 + oct_w + note_w + dur_w;
  endfunction

  function automatic int note_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int oct_lsb(input int note_w, input int dur_w);
    return dur_w + note_w;
  endfunction

  function automatic int end_bit(input int oct_w, input int note_w, input int dur_w);
    return dur_w + note_w + oct_w;
  endfunction

endpackage

// File: rtl/tune_tick_gen.sv
// Loadable clock divider: counts 0..div-1 while enabled and flags the terminal
// count as a one-cycle tick. A divisor of 0 is stored as 1 (tick every clock).
module tune_tick_gen (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [15:0] div,
  input  logic        clear,
  input  logic        en,
  output logic        tick
);

  logic [15:0] div_q;
  logic [15:0] cnt;

  assign tick = en && (cnt == div_q - 16'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= 16'd1;
      cnt   <= '0;
    end else begin
      if (load) div_q <= (div == 16'd0) ? 16'd1 : div;
      if (load || clear) cnt <= '0;
      else if (en)       cnt <= tick ? 16'd0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/tune_sequencer.sv
// Plays note events from a synchronous song memory and drives octave/note codes
// to a tone generator. Optional TUNE_SEQ_LOOP_EN adds a loop input that restarts the tune.
module tune_sequencer
  import tune_seq_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int OCT_W     = 4,
  parameter int NOTE_W    = 4,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      start,
  input  logic                                      stop,
  input  logic [15:0]                               tick_div,
`ifdef TUNE_SEQ_LOOP_EN
  input  logic                                      loop,
`endif
  output logic                                      mem_en,
  output logic [ADDR_W-1:0]                         mem_addr,
  input  logic [entry_w(OCT_W, NOTE_W, DUR_W)-1:0]  mem_rdata,
  output logic [OCT_W-1:0]                          octave,
  output logic [NOTE_W-1:0]                         note,
  output logic                                      busy,
  output logic                                      done,
  output state_t                                    dbg_state
);

  localparam int NOTE_LSB = note_lsb(DUR_W);
  localparam int OCT_LSB  = oct_lsb(NOTE_W, DUR_W);
  localparam int END_BIT  = end_bit(OCT_W, NOTE_W, DUR_W);

  localparam logic [DUR_W-1:0]  GAP_D = DUR_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [NOTE_W-1:0] REST  = NOTE_W'(NOTE_REST);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DUR_W-1:0]    remaining;
  logic [DUR_W-1:0]    dur_lat;
  logic                tick;
  logic                accept;
  logic                loop_req;

  logic                rd_end;
  logic [OCT_W-1:0]    rd_oct;
  logic [NOTE_W-1:0]   rd_note;
  logic [DUR_W-1:0]    rd_dur;
  logic [DUR_W-1:0]    rd_dur_eff;
  logic [ADDR_W-1:0]   ptr_nxt;

  assign rd_end     = mem_rdata[END_BIT];
  assign rd_oct     = mem_rdata[OCT_LSB +: OCT_W];
  assign rd_note    = mem_rdata[NOTE_LSB +: NOTE_W];
  assign rd_dur     = mem_rdata[DUR_W-1:0];
  assign rd_dur_eff = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
  // Wraps to 0 at the last address, which is exactly what looping needs.
  assign ptr_nxt    = ptr + ADDR_W'(1);
  assign accept     = (state == S_IDLE) && start && !stop;
  assign dbg_state  = state;

`ifdef TUNE_SEQ_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  tune_tick_gen u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .load  (accept),
    .div   (tick_div),
    .clear (state == S_WAIT),
    .en    (state == S_PLAY),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      dur_lat   <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      octave    <= '0;
      note      <= REST;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != S_IDLE) begin
        // Abort: silent and idle next cycle, no completion pulse.
        state     <= S_IDLE;
        ptr       <= '0;
        remaining <= '0;
        mem_en    <= 1'b0;
        mem_addr  <= '0;
        octave    <= '0;
        note      <= REST;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state    <= S_FETCH;
              ptr      <= '0;
              mem_en   <= 1'b1;
              mem_addr <= '0;
              busy     <= 1'b1;
            end
          end
          S_FETCH: begin
            mem_en <= 1'b0;
            state  <= S_WAIT;
          end
          S_WAIT: begin
            if (rd_end) begin
              octave <= '0;
              note   <= REST;
              if (loop_req) begin
                ptr      <= '0;
                mem_en   <= 1'b1;
                mem_addr <= '0;
                state    <= S_FETCH;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              octave    <= rd_oct;
              note      <= rd_note;
              remaining <= rd_dur_eff;
              dur_lat   <= rd_dur_eff;
              state     <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick) begin
              remaining <= remaining - DUR_W'(1);
              if (remaining == DUR_W'(1)) begin
                octave <= '0;
                note   <= REST;
                if (ptr == LAST && !loop_req) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  ptr      <= ptr_nxt;
                  mem_en   <= 1'b1;
                  mem_addr <= ptr_nxt;
                  state    <= S_FETCH;
                end
              end else if ((remaining - DUR_W'(1)) <= GAP_D && dur_lat > GAP_D) begin
                // Articulation gap: the last GAP_TICKS ticks of a long note are silent.
                octave <= '0;
                note   <= REST;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Self-checking bench for tune_sequencer (ADDR_W=2, GAP_TICKS=1) with a song memory model;
// a per-cycle expected trace of {done,busy,mem_en,mem_addr,octave,note} is queued and compared.
module tb_tune_sequencer;
  import tune_seq_pkg::*;

  localparam int ADDR_W = 2;
  localparam int GAP    = 1;
  localparam int SW     = 13;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] tick_div = 16'd0;
`ifdef TUNE_SEQ_LOOP_EN
  logic        loop = 1'b0;
`endif
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [14:0]       mem_rdata = '0;
  logic [3:0]        octave;
  logic [3:0]        note;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  logic [14:0]   mem [4];
  logic [SW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  tune_sequencer #(
    .ADDR_W(ADDR_W), .OCT_W(4), .NOTE_W(4), .DUR_W(6), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .tick_div(tick_div),
`ifdef TUNE_SEQ_LOOP_EN
    .loop(loop),
`endif
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .octave(octave), .note(note), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  function automatic logic [14:0] ent(input int e, input int o, input int n, input int d);
    return {1'(e), 4'(o), 4'(n), 6'(d)};
  endfunction

  // Builds the expected trace from the memory contents, starts the tune and checks every cycle.
  task automatic run_tune(input int div, input int poke);
    int d, dv, n;
    logic [SW-1:0] e, a, m;
    logic [14:0] en;
    exp_q.delete();
    dv = (div == 0) ? 1 : div;
    for (int i = 0; i < 4; i++) begin
      en = mem[i];
      exp_q.push_back({3'b011, 2'(i), 8'h00});
      exp_q.push_back({3'b010, 2'b00, 8'h00});
      if (en[14]) begin
        exp_q.push_back(13'h1000);
        break;
      end
      d = (en[5:0] == 6'd0) ? 1 : int'(en[5:0]);
      for (int t = 0; t < d * dv; t++) begin
        bit quiet;
        quiet = ((d - t / dv) <= GAP) && (d > GAP);
        exp_q.push_back({3'b010, 2'b00, quiet ? 8'h00 : en[13:6]});
      end
      if (i == 3) exp_q.push_back(13'h1000);
    end
    exp_q.push_back(13'h0000);

    @(posedge clk); #1;
    tick_div = 16'(div);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tick_div = 16'($urandom_range(2, 50));
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = {done, busy, mem_en, mem_addr, octave, note};
      m = '1;
      if (!e[10]) m[9:8] = 2'b00;
      checks++;
      if ((a & m) !== (e & m)) begin
        errors++;
        $display("FAIL trace cycle=%0d actual=%h expected=%h (done,busy,mem_en,addr,oct,note)",
                 n, a & m, e & m);
      end
      n++;
      @(posedge clk); #1;
      start = (n == poke);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (note !== 4'd0)       begin errors++; $display("FAIL reset_note actual=%0h expected=0", note); end
    checks++; if (octave !== 4'd0)     begin errors++; $display("FAIL reset_octave actual=%0h expected=0", octave); end
    checks++; if (mem_en !== 1'b0)     begin errors++; $display("FAIL reset_mem_en actual=%0b expected=0", mem_en); end
    checks++; if (mem_addr !== 2'd0)   begin errors++; $display("FAIL reset_mem_addr actual=%0h expected=0", mem_addr); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done actual=%0b expected=0", done); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state actual=%0d expected=0", dbg_state); end
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic_tune();
    mem[0] = ent(0, 4, 1, 2); mem[1] = ent(0, 5, 3, 1);
    mem[2] = ent(1, 0, 0, 0); mem[3] = ent(0, 0, 0, 0);
    run_tune(10, 0);
  endtask

  task automatic test_gap();
    mem[0] = ent(0, 2, 7, 4); mem[1] = ent(0, 6, 9, 1);
    mem[2] = ent(1, 0, 0, 0); mem[3] = ent(0, 0, 0, 0);
    run_tune(5, 0);
  endtask

  task automatic test_end_of_memory();
    mem[0] = ent(0, 1, 2, 3); mem[1] = ent(0, 3, 4, 1);
    mem[2] = ent(0, 7, 0, 0); mem[3] = ent(0, 8, 11, 2);
    run_tune(0, 0);
  endtask

  task automatic test_start_while_busy();
    mem[0] = ent(0, 4, 1, 2); mem[1] = ent(0, 5, 3, 1);
    mem[2] = ent(1, 0, 0, 0); mem[3] = ent(0, 0, 0, 0);
    run_tune(3, 9);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++)
        mem[i] = ent((i > 0 && $urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(1, 15),
                     $urandom_range(0, 15), $urandom_range(0, 4));
      run_tune($urandom_range(0, 3), 0);
    end
  endtask

  task automatic test_stop();
    int n;
    bit done_seen;
    mem[0] = ent(0, 4, 1, 1); mem[1] = ent(0, 5, 3, 3);
    mem[2] = ent(1, 0, 0, 0); mem[3] = ent(0, 0, 0, 0);
    @(posedge clk); #1; tick_div = 16'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!(dbg_state == S_PLAY && mem_addr == 2'd1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL stop_reach_play cycles=%0d limit=100", n); end
    repeat (3) @(posedge clk);
    #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL stop_state actual=%0d expected=0", dbg_state); end
    checks++; if (note !== 4'd0)        begin errors++; $display("FAIL stop_note actual=%0h expected=0", note); end
    checks++; if (octave !== 4'd0)      begin errors++; $display("FAIL stop_octave actual=%0h expected=0", octave); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL stop_busy actual=%0b expected=0", busy); end
    checks++; if (mem_en !== 1'b0)      begin errors++; $display("FAIL stop_mem_en actual=%0b expected=0", mem_en); end
    done_seen = done;
    repeat (6) begin @(negedge clk); done_seen |= done; end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL stop_no_done actual=%0b expected=0", done_seen); end
    run_tune(4, 0);
  endtask

  task automatic test_start_stop_same();
    bit en_seen, busy_seen;
    @(posedge clk); #1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    en_seen = mem_en; busy_seen = busy;
    repeat (4) begin @(posedge clk); #1; en_seen |= mem_en; busy_seen |= busy; end
    checks++; if (en_seen !== 1'b0)     begin errors++; $display("FAIL startstop_mem_en actual=%0b expected=0", en_seen); end
    checks++; if (busy_seen !== 1'b0)   begin errors++; $display("FAIL startstop_busy actual=%0b expected=0", busy_seen); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL startstop_state actual=%0d expected=0", dbg_state); end
  endtask

  task automatic test_async_reset();
    mem[0] = ent(0, 9, 5, 8); mem[1] = ent(1, 0, 0, 0);
    @(posedge clk); #1; tick_div = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #2; rstn = 1'b0;
    #1;
    checks++; if ({octave, note} !== 8'h00) begin errors++; $display("FAIL areset_note actual=%h expected=00", {octave, note}); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL areset_busy actual=%0b expected=0", busy); end
    checks++; if (dbg_state !== S_IDLE)    begin errors++; $display("FAIL areset_state actual=%0d expected=0", dbg_state); end
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

`ifdef TUNE_SEQ_LOOP_EN
  task automatic test_loop();
    int fetch0;
    bit done_seen, busy_low;
    mem[0] = ent(0, 4, 1, 1); mem[1] = ent(1, 0, 0, 0);
    loop = 1'b1;
    @(posedge clk); #1; tick_div = 16'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    fetch0 = 0; done_seen = 0; busy_low = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_en && mem_addr == 2'd0) fetch0++;
      done_seen |= done;
      busy_low |= !busy;
    end
    checks++; if (fetch0 < 2)         begin errors++; $display("FAIL loop_refetch actual=%0d expected>=2", fetch0); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL loop_no_done actual=%0b expected=0", done_seen); end
    checks++; if (busy_low !== 1'b0)  begin errors++; $display("FAIL loop_busy actual_low=%0b expected=0", busy_low); end
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0; loop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy actual=%0b expected=0", busy); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_basic_tune();
    test_gap();
    test_end_of_memory();
    test_start_while_busy();
    test_stop();
    test_start_stop_same();
    test_random();
    test_async_reset();
`ifdef TUNE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tune_sequencer.md
Name: tune_sequencer

Overview:
- Parametrised successor to the single-tune RTTTL sequencer: plays a tune of note events read from an external synchronous song memory.
- Drives octave/note codes to the downstream tone generator.
- Adds run-time tempo, per-note duration, articulation gap, stop/abort, busy/done status and configurable widths/depth.

Parameters:
- ADDR_W, 6, song memory address width; DEPTH = 2**ADDR_W entries
- OCT_W, 4, octave field width
- NOTE_W, 4, note field width; note code 0 = rest
- DUR_W, 6, duration field width, in ticks
- GAP_TICKS, 1, silent ticks at the end of each note; 0 = legato

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  level/pulse; begins playback from address 0 when idle
- stop  in  1  aborts playback
- tick_div  in  16  clocks per tick; sampled on accepted start; 0 treated as 1
- mem_en  out  1  song memory read enable
- mem_addr  out  ADDR_W  song memory address
- mem_rdata  in  1+OCT_W+NOTE_W+DUR_W  entry {end, octave, note, dur}; valid 1 cycle after mem_en
- octave  out  OCT_W  current octave
- note  out  NOTE_W  current note; 0 = silent
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal tune completion

Behaviour:
- Reset: state IDLE; octave, note, mem_addr, ptr, tick and duration counters = 0; mem_en, busy, done = 0.
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE:
  - start=1 and stop=0 → FETCH; ptr=0; latch tick_div; busy=1 next cycle.
  - start while busy is ignored.
- FETCH (1 cycle): mem_en=1, mem_addr=ptr → WAIT.
- WAIT (1 cycle): decode mem_rdata.
  - end=1: → IDLE; done pulses 1 cycle; octave/note=0.
  - Otherwise: latch octave/note; remaining=(dur==0 ? 1 : dur); clear tick counter → PLAY.
- PLAY:
  - Tick counter counts 0..tick_div-1; a tick fires on the terminal count, then the counter wraps.
  - Each tick decrements remaining.
  - If remaining<=GAP_TICKS and the latched duration is >GAP_TICKS, note/octave output 0; otherwise the latched values.
  - When remaining hits 0 on a tick:
    - If ptr==DEPTH-1: → IDLE with done pulse.
    - Else ptr+1 → FETCH.
- Latency:
  - start to first mem_en: 1 cycle.
  - mem_en to note valid: 2 cycles.
  - Inter-note fetch overhead: 2 cycles, output held at 0 during FETCH/WAIT.
- Note duration = dur*tick_div clocks + 2 fetch cycles.
- stop=1 in any busy state: → IDLE next cycle; outputs 0; busy=0; no done pulse; mem_en=0. stop wins over start in the same cycle.
- Reset mid-playback: immediate return to reset values.
- tick_div changes during playback are ignored until the next start.

Optional Feature:
- Macro TUNE_SEQ_LOOP_EN adds input port loop (1 bit).
- With the macro: on end marker or end of memory with loop=1, set ptr=0 → FETCH; no done pulse; busy stays high; playback continues until stop. With loop=0, behaviour is identical to the build without the macro.
- Without the macro: no loop port; the tune always ends with done.

Decomposition:
- Package tune_seq_pkg: state enum, entry field offsets/widths as functions of the parameters, NOTE_REST=0.
- One sub-module: tune_tick_gen (loadable clock divider with clear; emits one-cycle tick). The FSM stays in tune_sequencer.

Test Plan:
- Entries {0,4,1,2},{0,5,3,1},{1,…}; tick_div=10; GAP_TICKS=0 → note 1 for 20 clks, gap 2 clks, note 3 for 10 clks, then done pulse 1 cycle, busy low.
- GAP_TICKS=1, entry dur=4, tick_div=5 → note nonzero 15 clks, then 0 for 5 clks; dur=1 entry plays the full tick with no gap.
- stop asserted mid-PLAY of entry 1 → next cycle state IDLE, note=0, busy=0, no done; a subsequent start replays from address 0.
- start and stop in the same cycle from IDLE → stays IDLE, mem_en never asserted; start pulsed while busy → ptr unaffected.
- ADDR_W=2, four entries with no end marker, tick_div=0 → each note lasts dur clocks; done after address 3.
- TUNE_SEQ_LOOP_EN, loop=1, 2-entry tune → after the end marker mem_addr returns to 0, no done, busy stays 1; rstn low mid-note → all outputs 0 asynchronously.
